// File: rtl/smem_dram_pair_arbiter.sv
`default_nettype none
// smem_dram_pair_arbiter: round-robin arbitration of NUM_CH paired (k,l) line reads onto one TX_RD port, in-order pair return.
// Optional macro SMEM_PAIR_DEDUP_EN: a pair with k == l issues a single read and returns it on both lines.
module smem_dram_pair_arbiter #(
  parameter int NUM_CH   = 4,
  parameter int ADDR_W   = 58,
  parameter int DATA_W   = 512,
  parameter int OUT_LOG2 = 4
) (
  input  logic                     CLK_200M,
  input  logic                     reset_n,
  input  logic [NUM_CH-1:0]        req_valid,
  output logic [NUM_CH-1:0]        req_ready,
  input  logic [NUM_CH*ADDR_W-1:0] req_addr_k,
  input  logic [NUM_CH*ADDR_W-1:0] req_addr_l,
  input  logic                     stall,
  output logic                     tx_rd_valid,
  output logic [ADDR_W-1:0]        tx_rd_addr,
  input  logic                     rx_rd_valid,
  input  logic [DATA_W-1:0]        rx_data,
  output logic [NUM_CH-1:0]        rsp_valid,
  output logic [DATA_W-1:0]        rsp_data_k,
  output logic [DATA_W-1:0]        rsp_data_l,
  output logic [OUT_LOG2:0]        outstanding,
  output logic                     err_orphan
);

  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int DEPTH = 1 << OUT_LOG2;

  typedef logic [OUT_LOG2:0]   cnt_t;
  typedef logic [OUT_LOG2-1:0] ptr_t;
  typedef enum logic [1:0] {IDLE = 2'd0, SEND_K = 2'd1, SEND_L = 2'd2} state_t;
  typedef struct packed {
    logic [CH_W-1:0] ch;
    logic            dup;
  } tag_t;

  state_t            state;
  logic [CH_W-1:0]   last_grant;
  logic [ADDR_W-1:0] addr_k;
  logic [ADDR_W-1:0] addr_l;
  logic [CH_W-1:0]   ch_id;
  logic              dup;

  logic [CH_W-1:0]   pick;
  logic [CH_W-1:0]   hi_pick;
  logic [CH_W-1:0]   lo_pick;
  logic              hi_ok;
  logic              grant_ok;
  logic              grant;
  logic              grant_dup;
  logic [ADDR_W-1:0] sel_k;
  logic [ADDR_W-1:0] sel_l;

  tag_t              tag_mem [DEPTH];
  ptr_t              wr_ptr;
  ptr_t              rd_ptr;
  tag_t              head;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;

  logic              parity_l;
  logic [DATA_W-1:0] k_hold;

  // Lowest requester strictly above last_grant wins; otherwise wrap to the lowest requester.
  always_comb begin
    hi_ok   = 1'b0;
    hi_pick = '0;
    lo_pick = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        lo_pick = CH_W'(i);
        if (CH_W'(i) > last_grant) begin
          hi_ok   = 1'b1;
          hi_pick = CH_W'(i);
        end
      end
    end
    pick = hi_ok ? hi_pick : lo_pick;
  end

  assign full  = outstanding[OUT_LOG2];
  assign empty = (outstanding == '0);
  assign sel_k = req_addr_k[int'(pick)*ADDR_W +: ADDR_W];
  assign sel_l = req_addr_l[int'(pick)*ADDR_W +: ADDR_W];

`ifdef SMEM_PAIR_DEDUP_EN
  assign grant_dup = (sel_k == sel_l);
`else
  assign grant_dup = 1'b0;
`endif

  // A dup pair finishing in SEND_K behaves like a completed SEND_L, but its own tag is pushed this cycle.
  always_comb begin
    grant_ok = 1'b0;
    case (state)
      IDLE:    grant_ok = !full;
      SEND_K:  grant_ok = dup && !full && (outstanding != cnt_t'(DEPTH - 1));
      SEND_L:  grant_ok = !full;
      default: grant_ok = 1'b0;
    endcase
  end

  assign grant = reset_n && !stall && (|req_valid) && grant_ok;

  always_comb begin
    req_ready = '0;
    if (grant) req_ready[pick] = 1'b1;
  end

  always_ff @(posedge CLK_200M) begin
    if (!reset_n) begin
      state       <= IDLE;
      last_grant  <= '0;
      addr_k      <= '0;
      addr_l      <= '0;
      ch_id       <= '0;
      dup         <= 1'b0;
      tx_rd_valid <= 1'b0;
      tx_rd_addr  <= '0;
    end else begin
      tx_rd_valid <= 1'b0;
      if (grant) begin
        addr_k     <= sel_k;
        addr_l     <= sel_l;
        ch_id      <= pick;
        dup        <= grant_dup;
        last_grant <= pick;
      end
      case (state)
        IDLE: begin
          if (grant) state <= SEND_K;
        end
        SEND_K: begin
          if (!stall) begin
            tx_rd_valid <= 1'b1;
            tx_rd_addr  <= addr_k;
            if (dup) state <= grant ? SEND_K : IDLE;
            else     state <= SEND_L;
          end
        end
        SEND_L: begin
          if (!stall) begin
            tx_rd_valid <= 1'b1;
            tx_rd_addr  <= addr_l;
            state       <= grant ? SEND_K : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign push = (state == SEND_K) && !stall;
  assign head = tag_mem[rd_ptr];
  assign pop  = rx_rd_valid && !empty && (parity_l || head.dup);

  always_ff @(posedge CLK_200M) begin
    if (push) tag_mem[wr_ptr] <= '{ch: ch_id, dup: dup};
  end

  always_ff @(posedge CLK_200M) begin
    if (!reset_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      outstanding <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ptr_t'(1);
      if (pop)  rd_ptr <= rd_ptr + ptr_t'(1);
      case ({push, pop})
        2'b10:   outstanding <= outstanding + cnt_t'(1);
        2'b01:   outstanding <= outstanding - cnt_t'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

  always_ff @(posedge CLK_200M) begin
    if (!reset_n) begin
      parity_l   <= 1'b0;
      k_hold     <= '0;
      rsp_valid  <= '0;
      rsp_data_k <= '0;
      rsp_data_l <= '0;
      err_orphan <= 1'b0;
    end else begin
      rsp_valid <= '0;
      if (rx_rd_valid) begin
        if (empty) begin
          err_orphan <= 1'b1;
          parity_l   <= 1'b0;
        end else if (parity_l) begin
          rsp_valid[head.ch] <= 1'b1;
          rsp_data_k         <= k_hold;
          rsp_data_l         <= rx_data;
          parity_l           <= 1'b0;
        end else if (head.dup) begin
          rsp_valid[head.ch] <= 1'b1;
          rsp_data_k         <= rx_data;
          rsp_data_l         <= rx_data;
        end else begin
          k_hold   <= rx_data;
          parity_l <= 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_smem_dram_pair_arbiter.sv
`default_nettype none
// Directed self-checking bench for smem_dram_pair_arbiter (NUM_CH=4, OUT_LOG2=2).
module tb_smem_dram_pair_arbiter;

  localparam int NUM_CH   = 4;
  localparam int ADDR_W   = 58;
  localparam int DATA_W   = 512;
  localparam int OUT_LOG2 = 2;
  localparam int W        = DATA_W;

  logic                     clk = 1'b0;
  logic                     reset_n;
  logic [NUM_CH-1:0]        req_valid;
  logic [NUM_CH-1:0]        req_ready;
  logic [NUM_CH*ADDR_W-1:0] req_addr_k;
  logic [NUM_CH*ADDR_W-1:0] req_addr_l;
  logic                     stall;
  logic                     tx_rd_valid;
  logic [ADDR_W-1:0]        tx_rd_addr;
  logic                     rx_rd_valid;
  logic [DATA_W-1:0]        rx_data;
  logic [NUM_CH-1:0]        rsp_valid;
  logic [DATA_W-1:0]        rsp_data_k;
  logic [DATA_W-1:0]        rsp_data_l;
  logic [OUT_LOG2:0]        outstanding;
  logic                     err_orphan;

  int passed = 0;
  int fails  = 0;
  int total  = 0;

  logic [ADDR_W-1:0] txq [$];
  int                grq [$];
  int                tx_first;
  int                tx_last;
  int                rr_ch [4];

  smem_dram_pair_arbiter #(
    .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .OUT_LOG2(OUT_LOG2)
  ) dut (
    .CLK_200M(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr_k(req_addr_k), .req_addr_l(req_addr_l),
    .stall(stall),
    .tx_rd_valid(tx_rd_valid), .tx_rd_addr(tx_rd_addr),
    .rx_rd_valid(rx_rd_valid), .rx_data(rx_data),
    .rsp_valid(rsp_valid), .rsp_data_k(rsp_data_k), .rsp_data_l(rsp_data_l),
    .outstanding(outstanding), .err_orphan(err_orphan)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_addr(input int ch, input logic [ADDR_W-1:0] k, input logic [ADDR_W-1:0] l);
    req_addr_k[ch*ADDR_W +: ADDR_W] = k;
    req_addr_l[ch*ADDR_W +: ADDR_W] = l;
  endtask

  function automatic logic [W-1:0] dv(input int j);
    return {16{32'hC0DE_0000 + 32'(j)}};
  endfunction

  function automatic int oh2idx(input logic [NUM_CH-1:0] v);
    int r = -1;
    for (int i = 0; i < NUM_CH; i++) if (v[i]) r = i;
    return r;
  endfunction

  function automatic logic [ADDR_W-1:0] rr_k(input int ch);
    return ADDR_W'(32'h1000 + ch * 32'h10);
  endfunction

  initial begin
    reset_n     = 1'b0;
    req_valid   = '0;
    req_addr_k  = '0;
    req_addr_l  = '0;
    stall       = 1'b0;
    rx_rd_valid = 1'b0;
    rx_data     = '0;
    tx_first    = -1;
    tx_last     = -1;
    rr_ch       = '{1, 2, 3, 0};

    // Reset state
    repeat (3) cyc();
    check("rst_tx_valid", W'(tx_rd_valid), W'(0));
    check("rst_outstanding", W'(outstanding), W'(0));
    check("rst_rsp_valid", W'(rsp_valid), W'(0));
    check("rst_err_orphan", W'(err_orphan), W'(0));
    check("rst_req_ready", W'(req_ready), W'(0));
    reset_n = 1'b1;

    // Single channel pair
    set_addr(0, 'h100, 'h104);
    req_valid = 4'b0001;
    #1;
    check("single_req_ready", W'(req_ready), W'(4'b0001));
    cyc();
    req_valid = '0;
    cyc();
    check("single_tx_k_valid", W'(tx_rd_valid), W'(1));
    check("single_tx_k_addr", W'(tx_rd_addr), W'('h100));
    check("single_out_1", W'(outstanding), W'(1));
    cyc();
    check("single_tx_l_valid", W'(tx_rd_valid), W'(1));
    check("single_tx_l_addr", W'(tx_rd_addr), W'('h104));
    cyc();
    check("single_tx_idle", W'(tx_rd_valid), W'(0));
    rx_rd_valid = 1'b1;
    rx_data     = dv(1);
    cyc();
    check("single_no_rsp_after_k", W'(rsp_valid), W'(0));
    rx_data = dv(2);
    cyc();
    rx_rd_valid = 1'b0;
    check("single_rsp_valid", W'(rsp_valid), W'(4'b0001));
    check("single_rsp_k", rsp_data_k, dv(1));
    check("single_rsp_l", rsp_data_l, dv(2));
    check("single_out_0", W'(outstanding), W'(0));
    cyc();
    check("single_rsp_pulse", W'(rsp_valid), W'(0));
    check("single_hold_k", rsp_data_k, dv(1));
    check("single_hold_l", rsp_data_l, dv(2));

    // Round-robin from reset, filling the 4-deep tag FIFO
    reset_n   = 1'b0;
    req_valid = 4'b1111;
    for (int c = 0; c < NUM_CH; c++) set_addr(c, rr_k(c), rr_k(c) + 'h8);
    cyc();
    check("rr_rst_req_ready", W'(req_ready), W'(0));
    check("rr_rst_rsp_k", rsp_data_k, W'(0));
    reset_n = 1'b1;
    #1;
    for (int c = 0; c < 12; c++) begin
      if (req_ready != '0) grq.push_back(oh2idx(req_ready));
      if (tx_rd_valid) begin
        txq.push_back(tx_rd_addr);
        if (tx_first < 0) tx_first = c;
        tx_last = c;
      end
      cyc();
    end
    check("rr_grant_count", W'(grq.size()), W'(4));
    for (int i = 0; i < 4; i++) check($sformatf("rr_grant_%0d", i), W'(grq[i]), W'(rr_ch[i]));
    check("rr_tx_count", W'(txq.size()), W'(8));
    for (int i = 0; i < 8; i++)
      check($sformatf("rr_tx_addr_%0d", i), W'(txq[i]),
            W'(rr_k(rr_ch[i/2]) + ((i % 2 == 1) ? 'h8 : 'h0)));
    check("rr_tx_span", W'(tx_last - tx_first), W'(7));
    check("full_outstanding", W'(outstanding), W'(4));
    check("full_req_ready", W'(req_ready), W'(0));

    rx_rd_valid = 1'b1;
    rx_data     = dv(10);
    cyc();
    check("full_req_ready_k", W'(req_ready), W'(0));
    rx_data = dv(11);
    cyc();
    rx_rd_valid = 1'b0;
    #1;
    check("rr_rsp0_valid", W'(rsp_valid), W'(4'b0010));
    check("rr_rsp0_k", rsp_data_k, dv(10));
    check("rr_rsp0_l", rsp_data_l, dv(11));
    check("full_out_3", W'(outstanding), W'(3));
    check("full_regrant", W'(req_ready), W'(4'b0010));
    req_valid = '0;
    for (int j = 2; j < 8; j++) begin
      rx_rd_valid = 1'b1;
      rx_data     = dv(10 + j);
      cyc();
      if (j % 2 == 1) begin
        check($sformatf("rr_rsp%0d_valid", j / 2), W'(rsp_valid), W'(1 << rr_ch[j/2]));
        check($sformatf("rr_rsp%0d_k", j / 2), rsp_data_k, dv(9 + j));
        check($sformatf("rr_rsp%0d_l", j / 2), rsp_data_l, dv(10 + j));
      end
    end
    rx_rd_valid = 1'b0;
    cyc();
    check("rr_out_0", W'(outstanding), W'(0));
    check("rr_rsp_idle", W'(rsp_valid), W'(0));

    // Stall between K and L
    set_addr(0, 'h300, 'h308);
    req_valid = 4'b0001;
    #1;
    check("stall_req_ready", W'(req_ready), W'(4'b0001));
    cyc();
    req_valid = '0;
    cyc();
    check("stall_tx_k", W'(tx_rd_addr), W'('h300));
    check("stall_tx_k_valid", W'(tx_rd_valid), W'(1));
    stall = 1'b1;
    for (int s = 0; s < 5; s++) begin
      cyc();
      check($sformatf("stall_hold_%0d", s), W'(tx_rd_valid), W'(0));
    end
    stall = 1'b0;
    cyc();
    check("stall_tx_l_valid", W'(tx_rd_valid), W'(1));
    check("stall_tx_l", W'(tx_rd_addr), W'('h308));
    cyc();
    check("stall_tx_idle", W'(tx_rd_valid), W'(0));
    rx_rd_valid = 1'b1;
    rx_data     = dv(20);
    cyc();
    rx_data = dv(21);
    cyc();
    rx_rd_valid = 1'b0;
    check("stall_rsp_valid", W'(rsp_valid), W'(4'b0001));
    check("stall_rsp_k", rsp_data_k, dv(20));
    check("stall_rsp_l", rsp_data_l, dv(21));
    check("stall_out_0", W'(outstanding), W'(0));

    // Orphan response
    rx_rd_valid = 1'b1;
    rx_data     = dv(30);
    cyc();
    rx_rd_valid = 1'b0;
    check("orphan_set", W'(err_orphan), W'(1));
    check("orphan_no_rsp", W'(rsp_valid), W'(0));
    check("orphan_out", W'(outstanding), W'(0));
    cyc();
    check("orphan_sticky", W'(err_orphan), W'(1));

    // Reset in the middle of a pair
    set_addr(1, 'h400, 'h408);
    req_valid = 4'b0010;
    cyc();
    req_valid = '0;
    cyc();
    rx_rd_valid = 1'b1;
    rx_data     = dv(40);
    cyc();
    reset_n     = 1'b0;
    rx_rd_valid = 1'b0;
    cyc();
    check("mrst_tx_valid", W'(tx_rd_valid), W'(0));
    check("mrst_tx_addr", W'(tx_rd_addr), W'(0));
    check("mrst_outstanding", W'(outstanding), W'(0));
    check("mrst_rsp_valid", W'(rsp_valid), W'(0));
    check("mrst_err_orphan", W'(err_orphan), W'(0));
    check("mrst_rsp_k", rsp_data_k, W'(0));
    check("mrst_rsp_l", rsp_data_l, W'(0));
    reset_n = 1'b1;
    cyc();
    check("mrst_no_late_rsp", W'(rsp_valid), W'(0));
    set_addr(2, 'h500, 'h508);
    req_valid = 4'b0100;
    #1;
    check("mrst_req_ready", W'(req_ready), W'(4'b0100));
    cyc();
    req_valid = '0;
    repeat (3) cyc();
    rx_rd_valid = 1'b1;
    rx_data     = dv(50);
    cyc();
    rx_data = dv(51);
    cyc();
    rx_rd_valid = 1'b0;
    check("mrst_parity_rsp_valid", W'(rsp_valid), W'(4'b0100));
    check("mrst_parity_rsp_k", rsp_data_k, dv(50));
    check("mrst_parity_rsp_l", rsp_data_l, dv(51));

    // Equal k/l addresses
    set_addr(3, 'h200, 'h200);
    req_valid = 4'b1000;
    #1;
    check("dup_req_ready", W'(req_ready), W'(4'b1000));
    cyc();
    req_valid = '0;
    cyc();
    check("dup_tx_k_valid", W'(tx_rd_valid), W'(1));
    check("dup_tx_k_addr", W'(tx_rd_addr), W'('h200));
    cyc();
`ifdef SMEM_PAIR_DEDUP_EN
    check("dup_single_read", W'(tx_rd_valid), W'(0));
    check("dup_out_1", W'(outstanding), W'(1));
    rx_rd_valid = 1'b1;
    rx_data     = dv(60);
    cyc();
    rx_rd_valid = 1'b0;
    check("dup_rsp_valid", W'(rsp_valid), W'(4'b1000));
    check("dup_rsp_k", rsp_data_k, dv(60));
    check("dup_rsp_l", rsp_data_l, dv(60));
`else
    check("dup_second_read_valid", W'(tx_rd_valid), W'(1));
    check("dup_second_read_addr", W'(tx_rd_addr), W'('h200));
    cyc();
    check("dup_tx_idle", W'(tx_rd_valid), W'(0));
    rx_rd_valid = 1'b1;
    rx_data     = dv(60);
    cyc();
    rx_data = dv(61);
    cyc();
    rx_rd_valid = 1'b0;
    check("dup_rsp_valid", W'(rsp_valid), W'(4'b1000));
    check("dup_rsp_k", rsp_data_k, dv(60));
    check("dup_rsp_l", rsp_data_l, dv(61));
`endif
    check("dup_out_0", W'(outstanding), W'(0));
    cyc();
    check("dup_rsp_pulse", W'(rsp_valid), W'(0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/smem_dram_pair_arbiter.md
Name: smem_dram_pair_arbiter

Overview:
- Multi-channel successor to the single-engine BWT occurrence fetch path.
- NUM_CH independent SMEM engines each post a paired (addr_k, addr_l) cache-line read. The block arbitrates between them round-robin and issues the two reads back-to-back on one TX_RD port.
- It pairs in-order RX responses and returns both cache lines to the originating engine.
- It sits between the per-engine Top instances and the 200 MHz side of the request/response FIFOs.

Parameters:
- NUM_CH, 4, number of requesting engines (1..16).
- ADDR_W, 58, cache-line address width.
- DATA_W, 512, cache-line width.
- OUT_LOG2, 4, log2 of the maximum number of outstanding pairs (tag FIFO depth = 2**OUT_LOG2).

Ports:
- CLK_200M  in  1  core clock.
- reset_n  in  1  synchronous active-low reset.
- req_valid  in  NUM_CH  per-channel pair request.
- req_ready  out  NUM_CH  one-hot grant, combinational; handshake = valid & ready.
- req_addr_k  in  NUM_CH*ADDR_W  channel i occupies bits [i*ADDR_W +: ADDR_W].
- req_addr_l  in  NUM_CH*ADDR_W  same packing as req_addr_k.
- stall  in  1  TX almost-full (OR of rd/wr almostfull, registered and unregistered).
- tx_rd_valid  out  1  read request strobe.
- tx_rd_addr  out  ADDR_W  read address.
- rx_rd_valid  in  1  read response strobe; responses arrive in issue order.
- rx_data  in  DATA_W  response cache line.
- rsp_valid  out  NUM_CH  one-hot, one-cycle pulse when a pair is delivered.
- rsp_data_k  out  DATA_W  k cache line.
- rsp_data_l  out  DATA_W  l cache line.
- outstanding  out  OUT_LOG2+1  pairs issued but not yet delivered.
- err_orphan  out  1  sticky; set when a response arrives with no tag pending.

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, round-robin pointer 0, parity toggle at K, tag FIFO empty.
- Reset mid-operation: everything is discarded; no rsp_valid is issued for in-flight pairs.
- Grant condition: state is IDLE, or state is SEND_L and L is issued this cycle; and outstanding < 2**OUT_LOG2; and !stall; and any req_valid.
- Arbitration: grant the lowest requesting index strictly after last_grant, wrapping. req_ready is high for exactly that channel in that cycle.
- On grant: latch addr_k, addr_l and the channel id; update last_grant; next state SEND_K.
- FSM states: IDLE, SEND_K, SEND_L.
- SEND_K: if !stall, drive tx_rd_valid=1, tx_rd_addr=addr_k, push {ch_id, dup} into the tag FIFO, outstanding+1, then go to SEND_L. If stall, drive tx_rd_valid=0 and hold.
- SEND_L: if !stall, drive tx_rd_valid=1, tx_rd_addr=addr_l. Next state is SEND_K if a grant occurs this cycle, else IDLE. If stall, hold.
- tx_rd_valid and tx_rd_addr are registered: a request appears one cycle after its FSM issue decision.
- Throughput: one pair per 2 cycles when requests are continuous.
- Response side, on rx_rd_valid:
  - Parity K: capture rx_data into the k_hold register; parity becomes L.
  - Parity L: pop the tag FIFO; register rsp_valid[ch_id]=1, rsp_data_k=k_hold, rsp_data_l=rx_data; outstanding-1; parity becomes K.
- Latency: rsp_valid is asserted 1 cycle after the L response.
- Simultaneous increment and decrement of outstanding in the same cycle leaves it unchanged.
- rsp_data_k and rsp_data_l hold their last value when rsp_valid=0.
- Orphan response: rx_rd_valid at parity K while the tag FIFO is empty sets err_orphan and drops the data. err_orphan is cleared only by reset.
- Full: while outstanding == 2**OUT_LOG2, no grant is made; req_ready stays 0.

Optional Feature:
- Macro: SMEM_PAIR_DEDUP_EN.
- Defined:
  - On grant, dup = (addr_k == addr_l).
  - A dup pair issues only the K read; SEND_L is skipped, and the next state is IDLE or SEND_K exactly as if L had been issued.
  - When the head tag has dup=1, the single response delivers rx_data on both rsp_data_k and rsp_data_l. Parity stays at K; outstanding decrements.
- Undefined: dup is tied to 0 and every pair issues two reads.

Test Plan:
- Single channel: ch0 requests k=0x100, l=0x104 -> tx addresses 0x100 then 0x104 on consecutive cycles; responses A, B -> rsp_valid=0001, rsp_data_k=A, rsp_data_l=B, outstanding returns to 0.
- Round-robin: all 4 channels hold req_valid continuously from reset -> grant order 1,2,3,0,1...; 8 TX reads over 8 cycles; in-order responses go to channels 1,2,3,0.
- Stall: stall held for 5 cycles between the K and L issue -> tx_rd_valid=0 for 5 cycles, then L issued; the pair is delivered correctly.
- Full: OUT_LOG2=2, 4 pairs issued with no responses -> req_ready stays 0 and outstanding=4. One pair returned -> next grant occurs the cycle after delivery.
- Orphan/reset: rx_rd_valid with the tag FIFO empty -> err_orphan=1 and no rsp_valid. reset_n=0 for 1 cycle mid-pair -> all outputs 0 and parity back at K.
- Dedup (SMEM_PAIR_DEDUP_EN defined): k=l=0x200 -> a single tx read; response C -> rsp_data_k=rsp_data_l=C. With the macro undefined -> two reads of 0x200.
